// File: rtl/rr_arbiter8.sv
// Eight-input round-robin arbiter with registered one-hot grant, encoded index
// and optional bounded hold time that forces a one-cycle gap on expiry.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       e_i,
    input  logic [7:0] req_i,
    output logic [7:0] gnt_o,
    output logic [2:0] gnt_idx_o,
    output logic       gnt_valid_o,
    output logic       preempt_o
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state_q;
    logic [2:0] ptr_q;
    logic [7:0] hcnt_q;
    logic [7:0] gnt_q;
    logic [2:0] idx_q;
    logic       preempt_q;

    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;

    // Search starts at the pointer, so the most recent owner is always last in line.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            hcnt_q    <= 8'd0;
            gnt_q     <= 8'd0;
            idx_q     <= 3'd0;
            preempt_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, GAP: begin
                    preempt_q <= 1'b0;
                    if (e_i && win_found) begin
                        gnt_q   <= 8'd1 << win_idx;
                        idx_q   <= win_idx;
                        ptr_q   <= win_idx + 3'd1;
                        hcnt_q  <= 8'd1;
                        state_q <= GRANT;
                    end else begin
                        gnt_q   <= 8'd0;
                        idx_q   <= 3'd0;
                        hcnt_q  <= 8'd0;
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    if (!e_i) begin
                        gnt_q   <= 8'd0;
                        idx_q   <= 3'd0;
                        hcnt_q  <= 8'd0;
                        state_q <= IDLE;
                    end else if (!req_i[idx_q]) begin
                        // Owner let go: hand over immediately so the resource never idles.
                        if (win_found) begin
                            gnt_q   <= 8'd1 << win_idx;
                            idx_q   <= win_idx;
                            ptr_q   <= win_idx + 3'd1;
                            hcnt_q  <= 8'd1;
                            state_q <= GRANT;
                        end else begin
                            gnt_q   <= 8'd0;
                            idx_q   <= 3'd0;
                            hcnt_q  <= 8'd0;
                            state_q <= IDLE;
                        end
                    end else if (HOLD_LIMIT != 8'd0 && hcnt_q == HOLD_LIMIT) begin
                        gnt_q     <= 8'd0;
                        idx_q     <= 3'd0;
                        hcnt_q    <= 8'd0;
                        preempt_q <= 1'b1;
                        state_q   <= GAP;
                    end else if (hcnt_q != 8'hFF) begin
                        hcnt_q <= hcnt_q + 8'd1;
                    end
                end
                default: begin
                    gnt_q     <= 8'd0;
                    idx_q     <= 3'd0;
                    hcnt_q    <= 8'd0;
                    preempt_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = |gnt_q;
    assign preempt_o   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with a hold limit of 4 cycles; every expected
// output below is worked out by hand from the arbitration rules.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic       e;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gntIdx;
    logic       gntValid;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .e_i        (e),
        .req_i      (req),
        .gnt_o      (gnt),
        .gnt_idx_o  (gntIdx),
        .gnt_valid_o(gntValid),
        .preempt_o  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then let one rising edge pass and settle.
    task automatic applyStimulus(input logic r, input logic en, input logic [7:0] rq);
        rst = r;
        e   = en;
        req = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expGnt, input logic [2:0] expIdx,
                               input logic expValid, input logic expPre);
        checks++;
        assert (gnt === expGnt) else begin
            errors++;
            $error("[TB] FAIL %s gnt: observed %h expected %h", tag, gnt, expGnt);
        end
        checks++;
        assert (gntIdx === expIdx) else begin
            errors++;
            $error("[TB] FAIL %s gnt_idx: observed %0d expected %0d", tag, gntIdx, expIdx);
        end
        checks++;
        assert (gntValid === expValid) else begin
            errors++;
            $error("[TB] FAIL %s gnt_valid: observed %b expected %b", tag, gntValid, expValid);
        end
        checks++;
        assert (preempt === expPre) else begin
            errors++;
            $error("[TB] FAIL %s preempt: observed %b expected %b", tag, preempt, expPre);
        end
    endtask

    initial begin
        rst = 1'b1;
        e   = 1'b0;
        req = 8'h00;

        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'hFF);
        checkOutput("reset", 8'h00, 3'd0, 1'b0, 1'b0);

        // First grant from reset: pointer at 0.
        applyStimulus(1'b0, 1'b1, 8'h01);
        checkOutput("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);

        // All request, each owner drops for one cycle: 1,2,...,7,0 back to back.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 1'b1, 8'hFF & ~(8'd1 << (k - 1)));
            checkOutput($sformatf("rotate_%0d", k % 8), 8'd1 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
        end

        // Owner 0 hands to 2, then idle with pointer at 3.
        applyStimulus(1'b0, 1'b1, 8'h04);
        checkOutput("grant_2", 8'h04, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("idle_after_2", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h85);
        checkOutput("ptr3_win7", 8'h80, 3'd7, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h05);
        checkOutput("after7_win0", 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h04);
        checkOutput("after0_win2", 8'h04, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("req_zero_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Sole requester 4: four cycles of grant, one gap, then re-grant.
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(1'b0, 1'b1, 8'h10);
            checkOutput($sformatf("hold4_c%0d", c), 8'h10, 3'd4, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 8'h10);
        checkOutput("gap_sole", 8'h00, 3'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h10);
        checkOutput("regrant_4", 8'h10, 3'd4, 1'b1, 1'b0);

        // Requester 1 joins; after 4's hold expires it takes over.
        for (int c = 2; c <= 4; c++) begin
            applyStimulus(1'b0, 1'b1, 8'h12);
            checkOutput($sformatf("hold4b_c%0d", c), 8'h10, 3'd4, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 8'h12);
        checkOutput("gap_shared", 8'h00, 3'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h12);
        checkOutput("preempt_to_1", 8'h02, 3'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("idle_ptr2", 8'h00, 3'd0, 1'b0, 1'b0);

        // Enable low for three cycles releases owner 5 and blocks grants.
        applyStimulus(1'b0, 1'b1, 8'h20);
        checkOutput("grant_5", 8'h20, 3'd5, 1'b1, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b0, 1'b0, 8'h20);
            checkOutput($sformatf("e_low_%0d", c), 8'h00, 3'd0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 8'h20);
        checkOutput("e_back_5", 8'h20, 3'd5, 1'b1, 1'b0);

        // Reset mid-grant; pointer returns to 0 so 0 beats 7.
        applyStimulus(1'b1, 1'b1, 8'h20);
        checkOutput("rst_mid_grant", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h81);
        checkOutput("ptr0_win0", 8'h01, 3'd0, 1'b1, 1'b0);

        // Reset while in the gap.
        for (int c = 2; c <= 4; c++) begin
            applyStimulus(1'b0, 1'b1, 8'h01);
            checkOutput($sformatf("hold0_c%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 8'h01);
        checkOutput("gap_before_rst", 8'h00, 3'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h01);
        checkOutput("rst_in_gap", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h80);
        checkOutput("after_rst_win7", 8'h80, 3'd7, 1'b1, 1'b0);

        // Enable dropped during a gap: go idle and clear the pulse.
        for (int c = 2; c <= 4; c++) begin
            applyStimulus(1'b0, 1'b1, 8'h80);
            checkOutput($sformatf("hold7_c%0d", c), 8'h80, 3'd7, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 8'h80);
        checkOutput("gap7", 8'h00, 3'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h80);
        checkOutput("e_low_in_gap", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h80);
        checkOutput("e_low_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
